// File: rtl/debug_pkg.sv
// debug_pkg: shared constants, command codes and FSM encoding for the pipeline debug controller.
package debug_pkg;
    localparam int LEN = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_REG = 32;
    localparam int NB_CMD = 8;
    localparam int DUMP_WORDS = NB_REG + 1;
    localparam logic [7:0] CMD_RUN = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_DUMP = 8'h03;
    localparam logic [7:0] CMD_CLR = 8'h04;
    typedef enum logic [2:0] {IDLE, RUN, STEP, DUMP_LOAD, DUMP_SEND} state_t;
endpackage

// File: rtl/tx_word_serializer.sv
// tx_word_serializer: emits one loaded word as bytes, MSB first, on a valid/ready handshake.
module tx_word_serializer #(
    parameter int LEN = 32,
    parameter int NB = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [LEN-1:0] word,
    input  logic          ready,
    output logic [NB-1:0] data,
    output logic          valid,
    output logic          done
);
    localparam int NBYTES = LEN / NB;
    localparam int CW = $clog2(NBYTES + 1);
    logic [LEN-1:0] sh;
    logic [CW-1:0] cnt;
    logic last;
    always_comb begin
        last = cnt == CW'(NBYTES - 1);
        data = sh[LEN-1 -: NB];
        done = valid && ready && last;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh <= '0;
            cnt <= '0;
            valid <= 1'b0;
        end else if (load) begin
            sh <= word;
            cnt <= '0;
            valid <= 1'b1;
        end else if (valid && ready) begin
            sh <= sh << NB;
            cnt <= cnt + 1'b1;
            valid <= !last;
        end
    end
endmodule

// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl: UART-command driven run/step/halt gating of the pipeline enable,
// plus a register-file dump (cycle count + all registers) over a byte TX stream.
module pipeline_debug_ctrl
    import debug_pkg::*;
#(
    parameter int LEN = debug_pkg::LEN,
    parameter int NB_ADDR = debug_pkg::NB_ADDR,
    parameter int NB_REG = debug_pkg::NB_REG,
    parameter int NB_CMD = debug_pkg::NB_CMD
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_CMD-1:0]  i_cmd_data,
    input  logic               i_cmd_valid,
    input  logic               i_halt_instr,
    output logic               o_pipe_enable,
    output logic [NB_ADDR-1:0] o_dbg_reg_addr,
    input  logic [LEN-1:0]     i_dbg_reg_data,
    output logic [NB_CMD-1:0]  o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_halted,
    output logic [LEN-1:0]     o_cycle_count
);
    localparam int WIW = $clog2(DUMP_WORDS);
    state_t state, next_state;
    logic primed, load, done;
    logic [WIW-1:0] word_idx;
    logic [LEN-1:0] load_word;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (i_cmd_valid)
                next_state = (i_cmd_data == CMD_RUN && !o_halted) ? RUN :
                             (i_cmd_data == CMD_STEP && !o_halted) ? STEP :
                             (i_cmd_data == CMD_DUMP) ? DUMP_LOAD : IDLE;
            RUN: next_state = i_halt_instr ? IDLE : RUN;
            STEP: next_state = IDLE;
            DUMP_LOAD: next_state = (word_idx == '0 || primed) ? DUMP_SEND : DUMP_LOAD;
            DUMP_SEND: next_state = !done ? DUMP_SEND :
                                    (word_idx == WIW'(NB_REG)) ? IDLE : DUMP_LOAD;
            default: next_state = IDLE;
        endcase
    end
    // The counter cannot move while dumping, so it serves directly as the word-0 snapshot.
    always_comb begin
        o_busy = state != IDLE;
        load = state == DUMP_LOAD && next_state == DUMP_SEND;
        load_word = word_idx == '0 ? o_cycle_count : i_dbg_reg_data;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pipe_enable <= 1'b0;
            o_halted <= 1'b0;
            o_cycle_count <= '0;
            o_dbg_reg_addr <= '0;
            word_idx <= '0;
            primed <= 1'b0;
        end else begin
            o_pipe_enable <= next_state == RUN || next_state == STEP;
            primed <= state == DUMP_LOAD && next_state == DUMP_LOAD;
            if (state == IDLE && i_cmd_valid && i_cmd_data == CMD_CLR) begin
                o_cycle_count <= '0;
                o_halted <= 1'b0;
            end else if (o_pipe_enable) begin
                o_cycle_count <= &o_cycle_count ? o_cycle_count : o_cycle_count + 1'b1;
                if (i_halt_instr) o_halted <= 1'b1;
            end
            if (state == IDLE) word_idx <= '0;
            else if (state == DUMP_SEND && next_state == DUMP_LOAD) begin
                word_idx <= word_idx + 1'b1;
                o_dbg_reg_addr <= word_idx[NB_ADDR-1:0];
            end
        end
    end
    tx_word_serializer #(.LEN(LEN), .NB(NB_CMD)) u_ser (
        .clk(i_clk),
        .rst(i_rst),
        .load(load),
        .word(load_word),
        .ready(i_tx_ready),
        .data(o_tx_data),
        .valid(o_tx_valid),
        .done(done)
    );
endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// tb_pipeline_debug_ctrl: directed table vectors plus run/halt, dump, stall and reset-abort sequences.
module tb_pipeline_debug_ctrl;
    import debug_pkg::*;
    logic clk = 0, rst = 1;
    logic [7:0] cmd_data = 0;
    logic cmd_valid = 0, halt_instr = 0, tx_ready = 0;
    logic pipe_enable, tx_valid, busy, halted;
    logic [4:0] dbg_addr;
    logic [31:0] dbg_data = 0, cycle_count;
    logic [7:0] tx_data;
    int checks = 0, errors = 0;
    int n, nb;

    always #5 clk = ~clk;
    // Register file model: registered read, reg[n] = 0x1000_0000 + n.
    always @(posedge clk) dbg_data <= 32'h1000_0000 + 32'(dbg_addr);

    pipeline_debug_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_data(cmd_data), .i_cmd_valid(cmd_valid),
        .i_halt_instr(halt_instr), .o_pipe_enable(pipe_enable), .o_dbg_reg_addr(dbg_addr),
        .i_dbg_reg_data(dbg_data), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .o_busy(busy), .o_halted(halted), .o_cycle_count(cycle_count)
    );

    typedef struct {
        logic cv;
        logic [7:0] cmd;
        logic halt;
        logic en;
        logic bsy;
        logic [31:0] cnt;
        logic hl;
    } vec_t;
    vec_t vt[15];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        cmd_data = c;
        cmd_valid = 1;
        tick;
        cmd_valid = 0;
    endtask

    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] cnt);
        logic [31:0] w;
        w = (k / 4 == 0) ? cnt : 32'h1000_0000 + 32'(k / 4 - 1);
        return w[31 - 8 * (k % 4) -: 8];
    endfunction

    task automatic run_dump(input logic [31:0] cnt, input bit stall, input bit inject);
        int nbytes = 0, cyc = 0, last_xfer = -1;
        bit fin = 0, en_seen = 0, held_v = 0;
        logic [7:0] held = 0;
        send(CMD_DUMP);
        for (int i = 0; i < 3000 && !fin; i++) begin
            if (!busy) fin = 1;
            else begin
                cyc++;
                if (pipe_enable) en_seen = 1;
                if (held_v) check("stall_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
                tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                cmd_valid = inject && (i == 5 || i == 40 || i == 100);
                cmd_data = (i == 5) ? 8'h01 : 8'h7F;
                if (tx_valid && tx_ready) begin
                    check($sformatf("byte%0d", nbytes), {24'd0, tx_data}, {24'd0, exp_byte(nbytes, cnt)});
                    nbytes++;
                    last_xfer = cyc;
                end
                held_v = tx_valid && !tx_ready;
                held = tx_data;
                tick;
            end
        end
        cmd_valid = 0;
        tx_ready = 0;
        check("dump_done", {31'd0, busy}, 0);
        check("dump_bytes", nbytes, DUMP_WORDS * 4);
        check("dump_no_enable", {31'd0, en_seen}, 0);
        if (!stall) begin
            check("dump_cycles", cyc, 5 + 32 * 6);
            check("busy_falls", last_xfer, cyc);
        end
    endtask

    initial begin
        vt[0]  = '{1, 8'h02, 0, 1, 1, 0, 0};
        vt[1]  = '{0, 8'h00, 0, 0, 0, 1, 0};
        vt[2]  = '{0, 8'h00, 0, 0, 0, 1, 0};
        vt[3]  = '{1, 8'h02, 0, 1, 1, 1, 0};
        vt[4]  = '{0, 8'h00, 0, 0, 0, 2, 0};
        vt[5]  = '{1, 8'h02, 0, 1, 1, 2, 0};
        vt[6]  = '{0, 8'h00, 0, 0, 0, 3, 0};
        vt[7]  = '{1, 8'h7F, 0, 0, 0, 3, 0};
        vt[8]  = '{0, 8'h00, 1, 0, 0, 3, 0};
        vt[9]  = '{1, 8'h02, 0, 1, 1, 3, 0};
        vt[10] = '{0, 8'h00, 1, 0, 0, 4, 1};
        vt[11] = '{1, 8'h02, 0, 0, 0, 4, 1};
        vt[12] = '{1, 8'h01, 0, 0, 0, 4, 1};
        vt[13] = '{1, 8'h04, 0, 0, 0, 0, 0};
        vt[14] = '{0, 8'h00, 0, 0, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_en", {31'd0, pipe_enable}, 0);
        check("rst_tx_valid", {31'd0, tx_valid}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_addr", {27'd0, dbg_addr}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_halted", {31'd0, halted}, 0);
        check("rst_count", cycle_count, 0);
        rst = 0;
        tick;

        foreach (vt[i]) begin
            cmd_valid = vt[i].cv;
            cmd_data = vt[i].cmd;
            halt_instr = vt[i].halt;
            tick;
            cmd_valid = 0;
            halt_instr = 0;
            check($sformatf("v%0d_en", i), {31'd0, pipe_enable}, {31'd0, vt[i].en});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].bsy});
            check($sformatf("v%0d_count", i), cycle_count, vt[i].cnt);
            check($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vt[i].hl});
        end

        send(CMD_RUN);
        check("run_en_rise", {31'd0, pipe_enable}, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (pipe_enable) n++;
            halt_instr = (i == 20);
            tick;
        end
        halt_instr = 0;
        check("run_en_cycles", n, 21);
        check("run_count", cycle_count, 21);
        check("run_halted", {31'd0, halted}, 1);
        send(CMD_RUN);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (pipe_enable) n++;
            tick;
        end
        check("halted_run_ignored", n, 0);

        run_dump(32'h15, 0, 0);

        send(CMD_CLR);
        check("clr_count", cycle_count, 0);
        check("clr_halted", {31'd0, halted}, 0);

        run_dump(32'h0, 1, 1);

        send(CMD_DUMP);
        tx_ready = 1;
        nb = 0;
        for (int i = 0; i < 200 && nb < 10; i++) begin
            if (tx_valid) nb++;
            tick;
        end
        check("abort_bytes", nb, 10);
        #2 rst = 1;
        #1;
        check("abort_tx_valid", {31'd0, tx_valid}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_en", {31'd0, pipe_enable}, 0);
        tx_ready = 0;
        tick;
        rst = 0;
        tick;
        check("abort_tx_data", {24'd0, tx_data}, 0);

        run_dump(32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
